// File: rtl/pixel_sram_arbiter_if.sv
// Signal bundle between the pixel SRAM arbiter and its GPU, CPU and SRAM-pin neighbours.
// PIXEL_SRAM_READBACK_EN adds the CPU readback signals.
interface pixel_sram_arbiter_if;
  logic        gpu_active;
  logic [16:0] gpu_addr;
  logic [7:0]  gpu_data;

  logic        cpu_we;
  logic [16:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_ready;
  logic        cpu_overflow;

`ifdef PIXEL_SRAM_READBACK_EN
  logic        cpu_re;
  logic [16:0] cpu_raddr;
  logic [7:0]  cpu_rdata;
  logic        cpu_rvalid;
`endif

  logic [16:0] sram_addr;
  logic [7:0]  sram_dq_in;
  logic [7:0]  sram_dq_out;
  logic        sram_dq_oe;
  logic        sram_ce_n;
  logic        sram_oe_n;
  logic        sram_we_n;

  // Environment side: GPU, CPU and the SRAM data pins feeding the arbiter
  modport master (
    output gpu_active, gpu_addr, cpu_we, cpu_addr, cpu_wdata, sram_dq_in,
`ifdef PIXEL_SRAM_READBACK_EN
    output cpu_re, cpu_raddr,
    input  cpu_rdata, cpu_rvalid,
`endif
    input  gpu_data, cpu_ready, cpu_overflow,
    input  sram_addr, sram_dq_out, sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n
  );

  // Arbiter side
  modport slave (
    input  gpu_active, gpu_addr, cpu_we, cpu_addr, cpu_wdata, sram_dq_in,
`ifdef PIXEL_SRAM_READBACK_EN
    input  cpu_re, cpu_raddr,
    output cpu_rdata, cpu_rvalid,
`endif
    output gpu_data, cpu_ready, cpu_overflow,
    output sram_addr, sram_dq_out, sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n
  );
endinterface

// File: rtl/pixel_sram_arbiter.sv
// Pixel SRAM owner: GPU line-buffer reads win every cycle, buffered CPU writes fill the gaps.
// PIXEL_SRAM_READBACK_EN adds a CPU read path serviced only once the write FIFO is drained.
module pixel_sram_arbiter #(
  parameter int unsigned FIFO_DEPTH = 16
) (
  input logic                 clk,
  input logic                 reset,
  pixel_sram_arbiter_if.slave bus
);
  localparam int unsigned ADDR_W = 17;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned IDX_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned PTR_W  = IDX_W + 1;

  typedef enum logic [2:0] {
    IDLE,
    GPU_RD,
    WR_SETUP,
    WR_PULSE
`ifdef PIXEL_SRAM_READBACK_EN
    , CPU_RD
`endif
  } state_e;

  // state_d is the state in force this cycle; gpu_active overrides it without a cycle of delay
  state_e             state_q, state_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic               overflow_q, overflow_d;
  logic [DATA_W-1:0]  gpu_data_q, gpu_data_d;

  logic [ADDR_W-1:0]  fifo_addr_mem [FIFO_DEPTH];
  logic [DATA_W-1:0]  fifo_data_mem [FIFO_DEPTH];

  logic               fifo_empty_c, fifo_full_c, ready_c, push_c, pop_c;
  logic [ADDR_W-1:0]  head_addr_c;
  logic [DATA_W-1:0]  head_data_c;

  logic [ADDR_W-1:0]  sram_addr_c;
  logic [DATA_W-1:0]  sram_dq_out_c;
  logic               sram_dq_oe_c, sram_oe_n_c, sram_we_n_c;

`ifdef PIXEL_SRAM_READBACK_EN
  logic               rd_pend_q, rd_pend_d;
  logic [ADDR_W-1:0]  rd_addr_q, rd_addr_d;
  logic [DATA_W-1:0]  rdata_q, rdata_d;
  logic               rvalid_q, rvalid_d;
`endif

  assign fifo_empty_c = (wr_ptr_q == rd_ptr_q);
  assign fifo_full_c  = (wr_ptr_q[IDX_W] != rd_ptr_q[IDX_W]) &&
                        (wr_ptr_q[IDX_W-1:0] == rd_ptr_q[IDX_W-1:0]);
  assign head_addr_c  = fifo_addr_mem[rd_ptr_q[IDX_W-1:0]];
  assign head_data_c  = fifo_data_mem[rd_ptr_q[IDX_W-1:0]];

  // Priority: GPU, then finishing a started write, then queued writes, then readback
  always_comb begin
    state_d = IDLE;
    if (!reset) begin
      if (bus.gpu_active) begin
        state_d = GPU_RD;
      end else if (state_q == WR_SETUP) begin
        state_d = WR_PULSE;
      end else if (!fifo_empty_c) begin
        state_d = WR_SETUP;
      end
`ifdef PIXEL_SRAM_READBACK_EN
      else if (rd_pend_q) begin
        state_d = CPU_RD;
      end
`endif
    end
  end

  // FIFO bookkeeping; a push is judged on the pre-pop fullness
  always_comb begin
    ready_c    = !reset && !fifo_full_c;
    push_c     = bus.cpu_we && ready_c;
    pop_c      = (state_d == WR_PULSE);
    wr_ptr_d   = wr_ptr_q + PTR_W'(push_c);
    rd_ptr_d   = rd_ptr_q + PTR_W'(pop_c);
    overflow_d = overflow_q || (bus.cpu_we && !ready_c);
    gpu_data_d = (state_d == GPU_RD) ? bus.sram_dq_in : gpu_data_q;
  end

`ifdef PIXEL_SRAM_READBACK_EN
  // One outstanding read; new requests are ignored until it completes
  always_comb begin
    rd_pend_d = rd_pend_q;
    rd_addr_d = rd_addr_q;
    rvalid_d  = (state_d == CPU_RD);
    rdata_d   = rvalid_d ? bus.sram_dq_in : rdata_q;
    if (!rd_pend_q && bus.cpu_re) begin
      rd_pend_d = 1'b1;
      rd_addr_d = bus.cpu_raddr;
    end else if (rvalid_d) begin
      rd_pend_d = 1'b0;
    end
  end
`endif

  // SRAM pin decode from the effective state, so preemption and reset act within the cycle
  always_comb begin
    sram_addr_c   = '0;
    sram_dq_out_c = '0;
    sram_dq_oe_c  = 1'b0;
    sram_oe_n_c   = 1'b1;
    sram_we_n_c   = 1'b1;
    case (state_d)
      GPU_RD: begin
        sram_addr_c = bus.gpu_addr;
        sram_oe_n_c = 1'b0;
      end
      WR_SETUP, WR_PULSE: begin
        sram_addr_c   = head_addr_c;
        sram_dq_out_c = head_data_c;
        sram_dq_oe_c  = 1'b1;
        sram_we_n_c   = (state_d != WR_PULSE);
      end
`ifdef PIXEL_SRAM_READBACK_EN
      CPU_RD: begin
        sram_addr_c = rd_addr_q;
        sram_oe_n_c = 1'b0;
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
      gpu_data_q <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      overflow_q <= overflow_d;
      gpu_data_q <= gpu_data_d;
    end
  end

  // Storage needs no reset: pointers alone define validity
  always_ff @(posedge clk) begin
    if (push_c) begin
      fifo_addr_mem[wr_ptr_q[IDX_W-1:0]] <= bus.cpu_addr;
      fifo_data_mem[wr_ptr_q[IDX_W-1:0]] <= bus.cpu_wdata;
    end
  end

`ifdef PIXEL_SRAM_READBACK_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_pend_q <= 1'b0;
      rd_addr_q <= '0;
      rdata_q   <= '0;
      rvalid_q  <= 1'b0;
    end else begin
      rd_pend_q <= rd_pend_d;
      rd_addr_q <= rd_addr_d;
      rdata_q   <= rdata_d;
      rvalid_q  <= rvalid_d;
    end
  end

  assign bus.cpu_rdata  = reset ? '0 : rdata_q;
  assign bus.cpu_rvalid = rvalid_q && !reset;
`endif

  assign bus.gpu_data     = reset ? '0 : gpu_data_q;
  assign bus.cpu_ready    = ready_c;
  assign bus.cpu_overflow = overflow_q && !reset;
  assign bus.sram_addr    = sram_addr_c;
  assign bus.sram_dq_out  = sram_dq_out_c;
  assign bus.sram_dq_oe   = sram_dq_oe_c;
  assign bus.sram_oe_n    = sram_oe_n_c;
  assign bus.sram_we_n    = sram_we_n_c;
  assign bus.sram_ce_n    = reset;
endmodule

// File: tb/tb_pixel_sram_arbiter.sv
// Bench for pixel_sram_arbiter: behavioural SRAM, write log and occupancy model.
// Define PIXEL_SRAM_READBACK_EN for both RTL and bench to cover the readback path.
module tb_pixel_sram_arbiter;
  localparam int unsigned DEPTH = 16;

  typedef struct packed {
    logic [16:0] addr;
    logic [7:0]  data;
  } wr_t;

  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  logic [7:0] smem [0:131071];
  wr_t        log_q [$];

  pixel_sram_arbiter_if bus ();

  pixel_sram_arbiter #(.FIFO_DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Asynchronous-read SRAM; a byte is written and logged when WE is low at the clock edge
  assign bus.sram_dq_in = !bus.sram_oe_n ? smem[bus.sram_addr] : 8'h00;

  always @(posedge clk) begin
    if (!bus.sram_we_n && !bus.sram_ce_n && bus.sram_dq_oe) begin
      smem[bus.sram_addr] <= bus.sram_dq_out;
      log_q.push_back({bus.sram_addr, bus.sram_dq_out});
    end
  end

  task automatic test_reset();
    logic [38:0] got;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    got = {bus.sram_ce_n, bus.sram_we_n, bus.sram_oe_n, bus.sram_dq_oe, bus.sram_dq_out,
           bus.sram_addr, bus.gpu_data, bus.cpu_ready, bus.cpu_overflow};
    checks++;
    if (got !== {1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 17'h0, 8'h00, 1'b0, 1'b0}) begin
      errors++; $display("FAIL reset_during: got %h want %h", got, {1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 17'h0, 8'h00, 1'b0, 1'b0});
    end
    reset = 1'b0;
    @(negedge clk); #1;
    got = {bus.sram_ce_n, bus.sram_we_n, bus.sram_oe_n, bus.sram_dq_oe, bus.sram_dq_out,
           bus.sram_addr, bus.gpu_data, bus.cpu_ready, bus.cpu_overflow};
    checks++;
    if (got !== {1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 17'h0, 8'h00, 1'b1, 1'b0}) begin
      errors++; $display("FAIL reset_after: got %h want %h", got, {1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 17'h0, 8'h00, 1'b1, 1'b0});
    end
  endtask

  task automatic test_gpu_stream();
    for (int i = 0; i < 640; i++) begin
      @(negedge clk);
      if (i > 0) begin
        checks++;
        if (bus.gpu_data !== 8'(i - 1)) begin
          errors++; $display("FAIL gpu_stream_data[%0d]: got %h want %h", i - 1, bus.gpu_data, 8'(i - 1));
        end
      end
      bus.gpu_active = 1'b1;
      bus.gpu_addr   = 17'(i);
      #1;
      checks++;
      if ({bus.sram_we_n, bus.sram_oe_n, bus.sram_dq_oe, bus.sram_addr} !== {1'b1, 1'b0, 1'b0, 17'(i)}) begin
        errors++; $display("FAIL gpu_stream_pins[%0d]: got we_n=%b oe_n=%b oe=%b addr=%h", i,
                           bus.sram_we_n, bus.sram_oe_n, bus.sram_dq_oe, bus.sram_addr);
      end
    end
    @(negedge clk);
    bus.gpu_active = 1'b0;
    checks++;
    if (bus.gpu_data !== 8'h7f) begin
      errors++; $display("FAIL gpu_stream_last: got %h want 7f", bus.gpu_data);
    end
    @(negedge clk);
    checks++;
    if (bus.gpu_data !== 8'h7f) begin
      errors++; $display("FAIL gpu_data_hold: got %h want 7f", bus.gpu_data);
    end
  endtask

  task automatic test_idle_write();
    log_q.delete();
    @(negedge clk);
    bus.cpu_we = 1'b1; bus.cpu_addr = 17'h1ABCD; bus.cpu_wdata = 8'h5A;
    #1;
    checks++;
    if (bus.cpu_ready !== 1'b1) begin
      errors++; $display("FAIL idle_ready: got %b want 1", bus.cpu_ready);
    end
    @(negedge clk);
    bus.cpu_we = 1'b0;
    #1;
    checks++;
    if ({bus.sram_dq_oe, bus.sram_we_n, bus.sram_oe_n, bus.sram_addr, bus.sram_dq_out} !== {1'b1, 1'b1, 1'b1, 17'h1ABCD, 8'h5A}) begin
      errors++; $display("FAIL idle_setup: got oe=%b we_n=%b oe_n=%b addr=%h dq=%h", bus.sram_dq_oe, bus.sram_we_n,
                         bus.sram_oe_n, bus.sram_addr, bus.sram_dq_out);
    end
    @(negedge clk); #1;
    checks++;
    if ({bus.sram_dq_oe, bus.sram_we_n, bus.sram_oe_n, bus.sram_addr, bus.sram_dq_out} !== {1'b1, 1'b0, 1'b1, 17'h1ABCD, 8'h5A}) begin
      errors++; $display("FAIL idle_pulse: got oe=%b we_n=%b oe_n=%b addr=%h dq=%h", bus.sram_dq_oe, bus.sram_we_n,
                         bus.sram_oe_n, bus.sram_addr, bus.sram_dq_out);
    end
    @(negedge clk); #1;
    checks++;
    if (smem[17'h1ABCD] !== 8'h5A || log_q.size() != 1 || bus.sram_we_n !== 1'b1) begin
      errors++; $display("FAIL idle_result: got mem=%h writes=%0d we_n=%b want 5a 1 1", smem[17'h1ABCD], log_q.size(), bus.sram_we_n);
    end
  endtask

  task automatic test_preempt();
    int waited;
    log_q.delete();
    @(negedge clk);
    bus.cpu_we = 1'b1; bus.cpu_addr = 17'h00100; bus.cpu_wdata = 8'hC3;
    @(negedge clk);
    bus.cpu_we = 1'b0;
    @(negedge clk); #1;
    checks++;
    if (bus.sram_we_n !== 1'b0) begin
      errors++; $display("FAIL preempt_pulse_seen: got we_n=%b want 0", bus.sram_we_n);
    end
    bus.gpu_active = 1'b1; bus.gpu_addr = 17'h00042;
    #1;
    checks++;
    if ({bus.sram_we_n, bus.sram_dq_oe, bus.sram_oe_n, bus.sram_addr} !== {1'b1, 1'b0, 1'b0, 17'h00042}) begin
      errors++; $display("FAIL preempt_pins: got we_n=%b oe=%b oe_n=%b addr=%h", bus.sram_we_n, bus.sram_dq_oe,
                         bus.sram_oe_n, bus.sram_addr);
    end
    @(negedge clk);
    bus.gpu_active = 1'b0;
    checks++;
    if (bus.gpu_data !== 8'h42 || log_q.size() != 0) begin
      errors++; $display("FAIL preempt_read: got data=%h writes=%0d want 42 0", bus.gpu_data, log_q.size());
    end
    waited = 0;
    while (log_q.size() == 0 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    repeat (4) @(negedge clk);
    checks++;
    if (log_q.size() != 1 || smem[17'h00100] !== 8'hC3) begin
      errors++; $display("FAIL preempt_complete: got writes=%0d mem=%h want 1 c3", log_q.size(), smem[17'h00100]);
    end
  endtask

  task automatic test_full_fifo();
    wr_t exp_q [$];
    int  waited;
    log_q.delete();
    @(negedge clk);
    bus.gpu_active = 1'b1; bus.gpu_addr = 17'h0;
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      bus.cpu_we = 1'b1; bus.cpu_addr = 17'h08000 + 17'(i); bus.cpu_wdata = 8'hA0 + 8'(i);
      #1;
      checks++;
      if (bus.cpu_ready !== (i < 16)) begin
        errors++; $display("FAIL full_ready[%0d]: got %b want %b", i, bus.cpu_ready, (i < 16));
      end
      if (i < 16) exp_q.push_back({bus.cpu_addr, bus.cpu_wdata});
    end
    @(negedge clk);
    bus.cpu_we = 1'b0;
    checks++;
    if (bus.cpu_overflow !== 1'b1 || bus.cpu_ready !== 1'b0) begin
      errors++; $display("FAIL full_overflow: got ovf=%b ready=%b want 1 0", bus.cpu_overflow, bus.cpu_ready);
    end
    bus.gpu_active = 1'b0;
    waited = 0;
    while (log_q.size() < 16 && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    repeat (6) @(negedge clk);
    checks++;
    if (log_q.size() != 16) begin
      errors++; $display("FAIL full_drain_count: got %0d want 16", log_q.size());
    end
    for (int i = 0; i < 16 && i < log_q.size(); i++) begin
      checks++;
      if (log_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL full_order[%0d]: got %h want %h", i, log_q[i], exp_q[i]);
      end
    end
    checks++;
    if (bus.cpu_ready !== 1'b1 || bus.cpu_overflow !== 1'b1) begin
      errors++; $display("FAIL full_after: got ready=%b ovf=%b want 1 1", bus.cpu_ready, bus.cpu_overflow);
    end
  endtask

  task automatic test_reset_mid_write();
    int  waited;
    int  lows;
    logic seen;
    log_q.delete();
    @(negedge clk);
    bus.gpu_active = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus.cpu_we = 1'b1; bus.cpu_addr = 17'h0C000 + 17'(i); bus.cpu_wdata = 8'h11 + 8'(i);
    end
    @(negedge clk);
    bus.cpu_we = 1'b0; bus.gpu_active = 1'b0;
    seen = 1'b0; waited = 0;
    while (!seen && waited < 10) begin
      @(negedge clk); #1;
      seen = (bus.sram_we_n === 1'b0);
      waited++;
    end
    checks++;
    if (!seen) begin
      errors++; $display("FAIL rst_mid_pulse_timeout: got no we_n pulse within %0d cycles", waited);
    end
    reset = 1'b1;
    #1;
    checks++;
    if ({bus.sram_we_n, bus.sram_ce_n, bus.sram_dq_oe} !== 3'b110) begin
      errors++; $display("FAIL rst_mid_pins: got we_n=%b ce_n=%b oe=%b want 1 1 0", bus.sram_we_n, bus.sram_ce_n, bus.sram_dq_oe);
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk); #1;
    checks++;
    if (bus.cpu_ready !== 1'b1 || bus.cpu_overflow !== 1'b0) begin
      errors++; $display("FAIL rst_mid_after: got ready=%b ovf=%b want 1 0", bus.cpu_ready, bus.cpu_overflow);
    end
    lows = 0;
    repeat (20) begin
      @(negedge clk); #1;
      if (bus.sram_we_n !== 1'b1) lows++;
    end
    checks++;
    if (log_q.size() != 0 || lows != 0 || smem[17'h0C000] !== 8'h00) begin
      errors++; $display("FAIL rst_mid_no_writes: got writes=%0d we_lows=%0d mem=%h want 0 0 00", log_q.size(), lows, smem[17'h0C000]);
    end
  endtask

  // Random traffic against an occupancy/order model derived from the acceptance rules
  task automatic test_random();
    wr_t        exp_q [$];
    int         accepted;
    int         occ;
    int         waited;
    logic       gact, prev_gact, ovf_exp, exp_ready, we;
    logic [7:0] prev_exp;
    log_q.delete();
    accepted = 0; gact = 1'b0; prev_gact = 1'b0; ovf_exp = 1'b0; prev_exp = 8'h00;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      @(negedge clk);
      if (prev_gact) begin
        checks++;
        if (bus.gpu_data !== prev_exp) begin
          errors++; $display("FAIL rand_gpu_data[%0d]: got %h want %h", cyc, bus.gpu_data, prev_exp);
        end
      end
      checks++;
      if (bus.cpu_overflow !== ovf_exp) begin
        errors++; $display("FAIL rand_overflow[%0d]: got %b want %b", cyc, bus.cpu_overflow, ovf_exp);
      end
      if ($urandom_range(0, 7) == 0) gact = !gact;
      we = ($urandom_range(0, 1) == 1);
      bus.gpu_active = gact;
      bus.gpu_addr   = 17'($urandom);
      bus.cpu_we     = we;
      bus.cpu_addr   = 17'($urandom);
      bus.cpu_wdata  = 8'($urandom);
      #1;
      occ = accepted - log_q.size();
      exp_ready = (occ < DEPTH);
      checks++;
      if (bus.cpu_ready !== exp_ready) begin
        errors++; $display("FAIL rand_ready[%0d]: got %b want %b (occ %0d)", cyc, bus.cpu_ready, exp_ready, occ);
      end
      if (gact) begin
        checks++;
        if ({bus.sram_we_n, bus.sram_oe_n, bus.sram_addr} !== {1'b1, 1'b0, bus.gpu_addr}) begin
          errors++; $display("FAIL rand_gpu_pins[%0d]: got we_n=%b oe_n=%b addr=%h", cyc, bus.sram_we_n, bus.sram_oe_n, bus.sram_addr);
        end
      end
      if (we && exp_ready) begin
        exp_q.push_back({bus.cpu_addr, bus.cpu_wdata});
        accepted++;
      end
      if (we && !exp_ready) ovf_exp = 1'b1;
      prev_gact = gact;
      prev_exp  = smem[bus.gpu_addr];
    end
    @(negedge clk);
    bus.cpu_we = 1'b0; bus.gpu_active = 1'b0;
    waited = 0;
    while (log_q.size() < accepted && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    repeat (4) @(negedge clk);
    checks++;
    if (log_q.size() != exp_q.size()) begin
      errors++; $display("FAIL rand_drain_count: got %0d want %0d", log_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
      checks++;
      if (log_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL rand_order[%0d]: got %h want %h", i, log_q[i], exp_q[i]);
      end
    end
  endtask

`ifdef PIXEL_SRAM_READBACK_EN
  task automatic test_readback();
    int   waited;
    logic seen;
    log_q.delete();
    @(negedge clk);
    bus.cpu_we = 1'b1; bus.cpu_addr = 17'h00010; bus.cpu_wdata = 8'h33;
    @(negedge clk);
    bus.cpu_we = 1'b0; bus.cpu_re = 1'b1; bus.cpu_raddr = 17'h00010;
    @(negedge clk);
    bus.cpu_re = 1'b0;
    seen = 1'b0; waited = 0;
    while (!seen && waited < 20) begin
      if (bus.cpu_rvalid === 1'b1) seen = 1'b1;
      else begin
        @(negedge clk);
        waited++;
      end
    end
    checks++;
    if (!seen || bus.cpu_rdata !== 8'h33 || log_q.size() != 1) begin
      errors++; $display("FAIL readback: got seen=%b rdata=%h writes_before=%0d want 1 33 1", seen, bus.cpu_rdata, log_q.size());
    end
    @(negedge clk);
    checks++;
    if (bus.cpu_rvalid !== 1'b0) begin
      errors++; $display("FAIL readback_pulse: got rvalid=%b want 0", bus.cpu_rvalid);
    end
  endtask
`endif

  initial begin
    reset          = 1'b1;
    bus.gpu_active = 1'b0;
    bus.gpu_addr   = '0;
    bus.cpu_we     = 1'b0;
    bus.cpu_addr   = '0;
    bus.cpu_wdata  = '0;
`ifdef PIXEL_SRAM_READBACK_EN
    bus.cpu_re     = 1'b0;
    bus.cpu_raddr  = '0;
`endif
    for (int i = 0; i < 131072; i++) smem[i] <= 8'(i);

    test_reset();
    test_gpu_stream();
    test_idle_write();
    test_preempt();
    test_full_fifo();
    test_reset_mid_write();
    test_random();
`ifdef PIXEL_SRAM_READBACK_EN
    test_readback();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
